// File: rtl/uart_msg_seq.sv
// uart_msg_seq: streams a run-time loadable byte string into a
// start/ready byte transmitter, once or on a repeat loop with a gap.
module uart_msg_seq #(
  parameter int MSG_DEPTH  = 16,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0,
  parameter int AW         = $clog2(MSG_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW:0]       msg_len,
  input  logic              repeat_en,
  input  logic              send,
  input  logic              abort,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     cur_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(MSG_DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
  localparam logic [15:0] GAP_L   = 16'(GAP_CYCLES);

  logic [DATA_W-1:0] mem [MSG_DEPTH];

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [AW-1:0] idx;
  logic [AW:0]   len;
  logic [AW:0]   len_in;
  logic          rep;
  logic          abort_pend;
  logic [15:0]   gap_cnt;
  logic          wr_ok;
  logic          last;
  logic          gap_last;

  generate
    if (MSG_DEPTH == (1 << AW)) begin : g_pow2
      assign wr_ok = 1'b1;
    end else begin : g_npow2
      assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);
    end
  endgenerate

  assign len_in   = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
  assign last     = ({1'b0, idx} == (len - LEN_ONE));
  // counter holds the gap cycles still to spend, this one included
  assign gap_last = (gap_cnt <= 16'd1);

  // message buffer write port; reads see the pre-edge contents
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (send && (len_in != '0)) nxt = S_FETCH;
      end
      S_FETCH: begin
        nxt = abort ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)         nxt = S_IDLE;
        else if (tx_ready) nxt = S_ACK;
      end
      S_ACK: begin
        if (!tx_ready) begin
          nxt = (abort || abort_pend) ? S_IDLE : S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort || (last && !rep)) nxt = S_IDLE;
        else if (last)               nxt = S_GAP;
        else                         nxt = S_FETCH;
      end
      S_GAP: begin
        if (abort)         nxt = S_IDLE;
        else if (gap_last) nxt = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  // length and loop mode, captured on an accepted send
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len <= '0;
      rep <= 1'b0;
    end else if ((state == S_IDLE) && send) begin
      len <= len_in;
      rep <= repeat_en;
    end
  end

  // character index: cleared on send, stepped in NEXT, wrapped by GAP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if ((state == S_IDLE) && send) begin
      idx <= '0;
    end else if ((state == S_NEXT) && (nxt == S_FETCH)) begin
      idx <= idx + AW'(1);
    end else if ((state == S_GAP) && (nxt == S_FETCH)) begin
      idx <= '0;
    end
  end

  // inter-message gap counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt <= '0;
    end else if ((state == S_NEXT) && (nxt == S_GAP)) begin
      gap_cnt <= GAP_L;
    end else if (state == S_GAP) begin
      gap_cnt <= (gap_last || abort) ? '0 : gap_cnt - 16'd1;
    end
  end

  // remember an abort seen mid-handshake until the handshake closes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      abort_pend <= 1'b0;
    end else begin
      abort_pend <= (state == S_ACK) && (nxt == S_ACK) &&
                    (abort || abort_pend);
    end
  end

  // character fetch into the transmit data register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data <= '0;
      cur_idx <= '0;
    end else if (state == S_FETCH) begin
      tx_data <= mem[idx];
      cur_idx <= idx;
    end
  end

  // registered handshake and status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= (nxt == S_ACK);
      busy     <= (nxt != S_IDLE);
      done     <= ((state == S_IDLE) && send && (len_in == '0)) ||
                  ((state == S_NEXT) && (nxt == S_IDLE) && !abort);
    end
  end

endmodule

// File: tb/tb_uart_msg_seq.sv
// tb_uart_msg_seq: scoreboard bench for uart_msg_seq with a
// start/ready transmitter model and directed message vectors.
module tb_uart_msg_seq;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int GAP   = 5;
  localparam int AW    = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   msg_len;
  logic          repeat_en;
  logic          send;
  logic          abort;
  logic          tx_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  logic gate;
  logic mdl_rdy;
  int   late;
  int   xmit;

  int   n_vec = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   exp_done = 0;
  int   cyc = 0;

  exp_t       exp_q[$];
  int         start_cyc[$];
  int         hi_q[$];
  logic [7:0] mem_m [DEPTH];

  assign tx_ready = gate && mdl_rdy;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_msg_seq #(
    .MSG_DEPTH (DEPTH),
    .DATA_W    (DW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .msg_len  (msg_len),
    .repeat_en(repeat_en),
    .send     (send),
    .abort    (abort),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .cur_idx  (cur_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en    = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  task automatic send_req(input logic [4:0] l, input logic r);
    msg_len   = l;
    repeat_en = r;
    send      = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, expected 0", budget);
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!tx_start && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (!tx_start) begin
      n_vec++;
      n_fail++;
      $display("FAIL start_timeout: tx_start=0 after %0d cycles, expected 1", budget);
    end
  endtask

  // transmitter model: accepts a start, lingers, then is busy a while
  initial begin
    mdl_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && tx_ready) begin
        repeat (late) @(negedge clk);
        mdl_rdy = 1'b0;
        repeat (xmit) @(negedge clk);
        mdl_rdy = 1'b1;
      end
    end
  end

  // monitor: pops the scoreboard on every new transmit request
  initial begin
    exp_t e;
    logic prev;
    int   hi;
    prev = 1'b0;
    hi   = 0;
    e    = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev = 1'b0;
        hi   = 0;
      end else begin
        if (tx_start && !prev) begin
          start_cyc.push_back(cyc);
          hi = 1;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_start: data %0h idx %0h, expected no start",
                     tx_data, cur_idx);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
            chk("cur_idx", {28'd0, cur_idx}, {28'd0, e.idx});
          end
        end else if (tx_start) begin
          hi++;
          chk("tx_data_stable", {24'd0, tx_data}, {24'd0, e.data});
        end else if (prev) begin
          hi_q.push_back(hi);
        end
        if (done) done_seen++;
        prev = tx_start;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int hb;
    int n;
    rstn      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    msg_len   = '0;
    repeat_en = 1'b0;
    send      = 1'b0;
    abort     = 1'b0;
    gate      = 1'b1;
    late      = 0;
    xmit      = 2;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cur_idx", {28'd0, cur_idx}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // "Hi\r\n" with latency checks
    wr(4'd0, 8'h48);
    wr(4'd1, 8'h69);
    wr(4'd2, 8'h0D);
    wr(4'd3, 8'h0A);
    push(8'h48, 4'd0);
    push(8'h69, 4'd1);
    push(8'h0D, 4'd2);
    push(8'h0A, 4'd3);
    send_req(5'd4, 1'b0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_data", {24'd0, tx_data}, 32'h48);
    chk("lat_start_early", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("lat_start", {31'd0, tx_start}, 32'd1);
    wait_idle(200);
    exp_done++;
    chk("hi_done_cnt", done_seen, exp_done);
    chk("hi_q_empty", exp_q.size(), 32'd0);
    chk("hi_last_idx", {28'd0, cur_idx}, 32'd3);

    // zero-length send
    send_req(5'd0, 1'b0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("zero_done_fall", {31'd0, done}, 32'd0);
    exp_done++;
    @(negedge clk);
    chk("zero_done_cnt", done_seen, exp_done);

    // length clamp: 20 requested, 16 sent
    for (int i = 0; i < DEPTH; i++) begin
      wr(4'(i), 8'hA0 + 8'(i));
      push(8'hA0 + 8'(i), 4'(i));
    end
    send_req(5'd20, 1'b0);
    wait_idle(400);
    exp_done++;
    chk("clamp_done_cnt", done_seen, exp_done);
    chk("clamp_q_empty", exp_q.size(), 32'd0);
    chk("clamp_last_idx", {28'd0, cur_idx}, 32'd15);

    // repeat mode with gap, then abort in GAP
    wr(4'd0, 8'h31);
    wr(4'd1, 8'h32);
    base = start_cyc.size();
    for (int r = 0; r < 3; r++) begin
      push(8'h31, 4'd0);
      push(8'h32, 4'd1);
    end
    send_req(5'd2, 1'b1);
    n = 0;
    while ((exp_q.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("rep_q_empty", exp_q.size(), 32'd0);
    n = 0;
    while (tx_start && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("gap_abort_busy", {31'd0, busy}, 32'd0);
    chk("gap_abort_start", {31'd0, tx_start}, 32'd0);
    repeat (20) @(negedge clk);
    chk("rep_done_cnt", done_seen, exp_done);
    chk("rep_starts", start_cyc.size() - base, 32'd6);
    chk("rep_space_char", start_cyc[base+1] - start_cyc[base], 32'd4);
    chk("rep_space_gap1", start_cyc[base+2] - start_cyc[base+1], 32'd9);
    chk("rep_space_gap2", start_cyc[base+4] - start_cyc[base+3], 32'd9);

    // stalled ISSUE, late ACK, write and send while busy
    gate = 1'b0;
    wr(4'd0, 8'h55);
    wr(4'd1, 8'h66);
    push(8'h55, 4'd0);
    push(8'h77, 4'd1);
    send_req(5'd2, 1'b0);
    wr(4'd1, 8'h77);
    msg_len = 5'd1;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (8) @(negedge clk);
    chk("stall_no_start", {31'd0, tx_start}, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    late = 3;
    hb   = hi_q.size();
    gate = 1'b1;
    wait_idle(200);
    exp_done++;
    chk("stall_done_cnt", done_seen, exp_done);
    chk("stall_q_empty", exp_q.size(), 32'd0);
    chk("stall_ack_hold", hi_q[hb], 32'd4);

    // abort during ACK: handshake completes, no done
    push(mem_m[0], 4'd0);
    hb = hi_q.size();
    send_req(5'd3, 1'b0);
    wait_start(20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(100);
    chk("ack_abort_done_cnt", done_seen, exp_done);
    chk("ack_abort_q_empty", exp_q.size(), 32'd0);
    chk("ack_abort_hold", hi_q[hb], 32'd4);
    chk("ack_abort_start", {31'd0, tx_start}, 32'd0);

    // reset mid-ACK, then a fresh message from index 0
    push(mem_m[0], 4'd0);
    send_req(5'd4, 1'b0);
    wait_start(20);
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mid_rst_cur_idx", {28'd0, cur_idx}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    late = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_q_empty", exp_q.size(), 32'd0);
    push(mem_m[0], 4'd0);
    push(mem_m[1], 4'd1);
    send_req(5'd2, 1'b0);
    wait_idle(100);
    exp_done++;
    chk("post_rst_done_cnt", done_seen, exp_done);
    chk("post_rst_q_done", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_msg_seq.md
# uart_msg_seq

Parametrised message sequencer that streams a run-time loadable byte string into a `uart_tx`-style byte transmitter.
- The message lives in an internal write-port buffer.
- Each `send` transmits `msg_len` bytes through the transmitter's `start`/`ready` handshake, once or repeatedly with a programmable gap.
- Sits between a host/loader (or constant-drive logic) and `uart_tx`, replacing fixed-string, free-running transmit FSMs.

## Interface
- `MSG_DEPTH`, 16: buffer entries, ≥2; `AW = $clog2(MSG_DEPTH)`.
- `DATA_W`, 8: bits per character.
- `GAP_CYCLES`, 0: idle clk cycles between repeated messages, 0..2^16-1.
- `clk` in 1: the block's single clock; all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in AW: buffer write address; writes with `wr_addr ≥ MSG_DEPTH` are dropped.
- `wr_data` in DATA_W: buffer write data.
- `msg_len` in AW+1: characters per message; sampled on accepted `send`.
- `repeat_en` in 1: loop mode; sampled on accepted `send`.
- `send` in 1: start request; accepted only when idle.
- `abort` in 1: stop request.
- `tx_ready` in 1: transmitter idle / able to accept.
- `tx_start` out 1: transmit request to transmitter.
- `tx_data` out DATA_W: character to transmitter.
- `busy` out 1: high whenever not IDLE (registered).
- `done` out 1: one-cycle pulse on normal completion.
- `cur_idx` out AW: index of the character being sent.

## Operation
- Buffer: `MSG_DEPTH` × `DATA_W`, not reset. The write takes effect on the edge where `wr_en=1`.
- Writes are legal at any time, including while busy.
  - A write affects only characters fetched later.
  - A same-edge write and fetch to the same address fetch the old data.
- Latched length: `len = min(msg_len, MSG_DEPTH)`. The latched `len` and `rep` are held until return to IDLE.
- IDLE:
  - `send=1` and `len≠0` → FETCH, with `idx=0`.
  - `send=1` and `len=0` → `done` pulse next cycle; stays IDLE.
  - `send` while busy is ignored.
- FETCH: `tx_data <= buf[idx]`, `cur_idx <= idx` → ISSUE.
- ISSUE: if `tx_ready=1`, `tx_start <= 1` → ACK. Otherwise wait in ISSUE.
- ACK: hold `tx_start=1` and `tx_data` stable. When `tx_ready=0` is sampled, `tx_start <= 0` → NEXT.
- NEXT:
  - `idx = len-1` and `rep=0` → `done` pulse, IDLE.
  - `idx = len-1` and `rep=1` → GAP.
  - Otherwise `idx <= idx+1` → FETCH.
- GAP: 16-bit counter loads `GAP_CYCLES`. At 0: `idx <= 0` → FETCH. With `GAP_CYCLES=0`, GAP lasts exactly one cycle.
- abort (level, sampled each edge):
  - In IDLE: no effect.
  - In FETCH, ISSUE, NEXT or GAP: → IDLE next edge with `tx_start=0`; no `done`.
  - In ACK: the handshake completes first; `tx_start` is never dropped before `tx_ready=0` is seen. Then → IDLE, no `done`.
  - Simultaneous `abort` and `send` in IDLE: `send` wins.
- `tx_data` holds its last value in IDLE.

## Timing
- Reset (async assert, sync use after release):
  - `state=IDLE`, `idx=0`, `cur_idx=0`.
  - `tx_start=0`, `tx_data=0`, `busy=0`, `done=0`.
  - Gap counter 0.
- All outputs are registered; none combinational from inputs.
- `send` sampled at edge E0 → `busy=1` after E0, `tx_data` valid after E1, `tx_start=1` after E2 (if `tx_ready=1` at E2).
- Per character: FETCH(1) + ISSUE(≥1) + ACK(≥1) + NEXT(1) cycles plus transmitter time. The minimum inter-start spacing is 4 cycles.
- `done` asserts for exactly one cycle, on the edge leaving NEXT; `busy` falls on the same edge.
- `cur_idx` wraps only via GAP, back to 0; `idx` never exceeds `len-1`.
- Reset mid-ACK drops `tx_start` immediately (asynchronous). The transmitter is reset alongside.

## Test plan
- Load "Hi\r\n" at 0..3, `msg_len=4`, `send` pulse, transmitter model ready → starts carry 0x48, 0x69, 0x0D, 0x0A in order; one `done`; `busy` low afterwards.
- `msg_len=0` `send` → no `tx_start`; `done` one cycle after; `busy` stays 0. `msg_len=20` with `MSG_DEPTH=16` → exactly 16 characters.
- `repeat_en=1`, `GAP_CYCLES=5`, `len=2` → sequence 0,1,gap,0,1… Gap = 5 cycles from NEXT exit to FETCH; never `done`.
- `tx_ready` held low 10 cycles during ISSUE, then ACK with `tx_ready` low only 3 cycles late → `tx_start` high continuously until accept; `tx_data` stable throughout.
- `abort` during ACK → handshake finishes, then IDLE, no `done`. `abort` during GAP → IDLE next edge. `send` during busy → ignored.
- `rstn` asserted mid-message → all outputs at reset values asynchronously. A fresh `send` after release restarts at index 0.
